// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Signed operations run on magnitudes; the sign is restored in a single FIX cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opnd;
    logic                 is_div, neg_q, neg_r;
    logic                 accept, wr_hi, wr_lo, step, commit;
    logic [WIDTH-1:0]     res_hi, res_lo;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic is_signed);
        logic signed [WIDTH-1:0] sx;
        sx = x;
        return (is_signed && sx < 0) ? $unsigned(-sx) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] mcand);
        logic [WIDTH:0] sum;
        sum = {1'b0, x[2*WIDTH-1:WIDTH]} + {1'b0, (x[0] ? mcand : {WIDTH{1'b0}})};
        return {sum, x[WIDTH-1:1]};
    endfunction

    // Restoring division: remainder in the high half, quotient shifts in at bit 0.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] dvsr);
        logic [WIDTH:0] rsh, diff;
        rsh  = x[2*WIDTH-1:WIDTH-1];
        diff = rsh - {1'b0, dvsr};
        if (!diff[WIDTH])
            return {diff[WIDTH-1:0], x[WIDTH-2:0], 1'b1};
        return {rsh[WIDTH-1:0], x[WIDTH-2:0], 1'b0};
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = RUN;
            RUN: begin
                if (flush)                  state_nxt = IDLE;
                else if (cnt == CW'(1))     state_nxt = FIX;
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != IDLE);
        accept = (state == IDLE) && start && !flush && !op[2];
        wr_hi  = (state == IDLE) && start && !flush && (op == 3'd4);
        wr_lo  = (state == IDLE) && start && !flush && (op == 3'd5);
        step   = (state == RUN) && !flush;
        commit = (state == FIX) && !flush;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            is_div <= op[1];
            neg_q  <= op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r  <= op[0] && op[1] && a[WIDTH-1];
            if (op[1]) begin
                acc  <= {{WIDTH{1'b0}}, magnitude(a, op[0])};
                opnd <= magnitude(b, op[0]);
            end else begin
                acc  <= {{WIDTH{1'b0}}, magnitude(b, op[0])};
                opnd <= magnitude(a, op[0]);
            end
        end else if (step) begin
            acc <= is_div ? div_step(acc, opnd) : mul_step(acc, opnd);
        end
    end

    // Sign restoration; a zero divisor forces LO to all ones and HI back to a.
    always_comb begin
        logic [2*WIDTH-1:0] prod;
        prod   = neg_q ? -acc : acc;
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (is_div) begin
            res_lo = div_zero ? {WIDTH{1'b1}}
                              : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
            res_hi = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= commit;
            if (accept) begin
                cnt      <= CW'(WIDTH);
                div_zero <= op[1] && (b == '0);
            end else if (step) begin
                cnt <= cnt - CW'(1);
            end
            if (commit) begin
                hi <= res_hi;
                lo <= res_lo;
            end else begin
                if (wr_hi) hi <= a;
                if (wr_lo) lo <= a;
            end
        end
    end

    assign rd_data = hi_sel ? hi : lo;

endmodule
